// File: rtl/core_pkg.sv
// Shared definitions for the retire end of the decode issue protocol.
//   ROB_ENTRIES/ID_W/DATA_W/REG_W/XT_W : geometry of the reorder buffer
//   slot_state_e                       : per-slot lifecycle FREE -> PEND -> DONE
//   XT_*                               : exception type codes carried in xtype
//   rob_entry_t                        : captured writeback payload of one slot
package core_pkg;

   localparam int unsigned ROB_ENTRIES = 8;
   localparam int unsigned ID_W        = 3;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned XT_W        = 3;
   localparam int unsigned CNT_W       = ID_W + 1;

   typedef enum logic [1:0] {
      SLOT_FREE = 2'd0,
      SLOT_PEND = 2'd1,
      SLOT_DONE = 2'd2
   } slot_state_e;

   localparam logic [XT_W-1:0] XT_NONE    = 3'd0;
   localparam logic [XT_W-1:0] XT_FETCH   = 3'd1;
   localparam logic [XT_W-1:0] XT_MEM     = 3'd2;
   localparam logic [XT_W-1:0] XT_ILLEGAL = 3'd3;

   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic              xcpt;
      logic [XT_W-1:0]   xtype;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] xaddr;
   } rob_entry_t;

endpackage

// File: rtl/rob_wb_merge.sv
// Writeback arbitration between the ALU and MUL result ports.
//   pend_i            : one bit per slot, slot currently PEND
//   alu_valid_i/id_i  : ALU writeback strobe and target slot
//   mul_valid_i/id_i  : MUL writeback strobe and target slot
//   alu_cap_o         : ALU payload is to be captured into slot alu_id_i
//   mul_cap_o         : MUL payload is to be captured into slot mul_id_i
//   err_o             : writeback to a non-PEND slot or ALU/MUL id collision
module rob_wb_merge
   import core_pkg::*;
(
   input  logic [ROB_ENTRIES-1:0] pend_i,
   input  logic                   alu_valid_i,
   input  logic [ID_W-1:0]        alu_id_i,
   input  logic                   mul_valid_i,
   input  logic [ID_W-1:0]        mul_id_i,
   output logic                   alu_cap_o,
   output logic                   mul_cap_o,
   output logic                   err_o
);

   logic collide;

   always_comb begin
      collide   = alu_valid_i & mul_valid_i & (alu_id_i == mul_id_i);
      alu_cap_o = alu_valid_i & pend_i[alu_id_i];
      // On a same-id collision the ALU result is kept and MUL is dropped.
      mul_cap_o = mul_valid_i & pend_i[mul_id_i] & ~collide;
      err_o     = (alu_valid_i & ~pend_i[alu_id_i])
                | (mul_valid_i & ~pend_i[mul_id_i])
                | collide;
   end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: collects out-of-order ALU/MUL writebacks by id and retires
// them strictly in order to the register file, or raises an exception + flush.
//   clock, reset            : core clock, synchronous active-high reset
//   alloc_valid/alloc_id    : decode issue; alloc_id must equal the tail
//   alu_wb_*, mul_wb_*      : writeback ports (valid,id,we,rd,data,xcpt,xtype,pc,xaddr)
//   writeEnRF/writeValRF/destRF/write_idRF : registered retire write port
//   xcpt_valid/rmPC/rmAddr/xcpt_type       : registered exception report
//   flush_rob               : one-cycle flush pulse alongside xcpt_valid
//   rob_full/rob_empty      : occupancy from the registered count
//   rob_err                 : sticky protocol-error flag
module reorder_buffer
   import core_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              alloc_valid,
   input  logic [ID_W-1:0]   alloc_id,
   input  logic              alu_wb_valid,
   input  logic [ID_W-1:0]   alu_wb_id,
   input  logic              alu_wb_we,
   input  logic [REG_W-1:0]  alu_wb_rd,
   input  logic [DATA_W-1:0] alu_wb_data,
   input  logic              alu_wb_xcpt,
   input  logic [XT_W-1:0]   alu_wb_xtype,
   input  logic [DATA_W-1:0] alu_wb_pc,
   input  logic [DATA_W-1:0] alu_wb_xaddr,
   input  logic              mul_wb_valid,
   input  logic [ID_W-1:0]   mul_wb_id,
   input  logic              mul_wb_we,
   input  logic [REG_W-1:0]  mul_wb_rd,
   input  logic [DATA_W-1:0] mul_wb_data,
   input  logic              mul_wb_xcpt,
   input  logic [XT_W-1:0]   mul_wb_xtype,
   input  logic [DATA_W-1:0] mul_wb_pc,
   input  logic [DATA_W-1:0] mul_wb_xaddr,
   output logic              writeEnRF,
   output logic [DATA_W-1:0] writeValRF,
   output logic [REG_W-1:0]  destRF,
   output logic [ID_W-1:0]   write_idRF,
   output logic              xcpt_valid,
   output logic [DATA_W-1:0] rmPC,
   output logic [DATA_W-1:0] rmAddr,
   output logic [XT_W-1:0]   xcpt_type,
   output logic              flush_rob,
   output logic              rob_full,
   output logic              rob_empty,
   output logic              rob_err
);

   slot_state_e       state_q [ROB_ENTRIES];
   slot_state_e       state_d [ROB_ENTRIES];
   rob_entry_t        entry_q [ROB_ENTRIES];
   rob_entry_t        entry_d [ROB_ENTRIES];
   logic [ID_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q, err_d;

   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wval_q, wval_d;
   logic [REG_W-1:0]  dest_q, dest_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic              xv_q, xv_d;
   logic [DATA_W-1:0] rmpc_q, rmpc_d;
   logic [DATA_W-1:0] rmaddr_q, rmaddr_d;
   logic [XT_W-1:0]   xt_q, xt_d;
   logic              flush_q, flush_d;

   logic [ROB_ENTRIES-1:0] pend;
   logic              alu_cap, mul_cap, merge_err;
   logic              do_alloc, do_retire;
   rob_entry_t        alu_ent, mul_ent, head_ent;

   assign alu_ent = '{we: alu_wb_we, rd: alu_wb_rd, data: alu_wb_data, xcpt: alu_wb_xcpt,
                      xtype: alu_wb_xtype, pc: alu_wb_pc, xaddr: alu_wb_xaddr};
   assign mul_ent = '{we: mul_wb_we, rd: mul_wb_rd, data: mul_wb_data, xcpt: mul_wb_xcpt,
                      xtype: mul_wb_xtype, pc: mul_wb_pc, xaddr: mul_wb_xaddr};
   assign head_ent = entry_q[head_q];

   always_comb begin
      for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
         pend[i] = (state_q[i] == SLOT_PEND);
      end
   end

   rob_wb_merge u_wb_merge (
      .pend_i      (pend),
      .alu_valid_i (alu_wb_valid),
      .alu_id_i    (alu_wb_id),
      .mul_valid_i (mul_wb_valid),
      .mul_id_i    (mul_wb_id),
      .alu_cap_o   (alu_cap),
      .mul_cap_o   (mul_cap),
      .err_o       (merge_err)
   );

   assign rob_full  = (count_q == CNT_W'(ROB_ENTRIES));
   assign rob_empty = (count_q == '0);

   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      err_d     = err_q;
      wen_d     = 1'b0;
      wval_d    = wval_q;
      dest_d    = dest_q;
      wid_d     = wid_q;
      xv_d      = 1'b0;
      rmpc_d    = rmpc_q;
      rmaddr_d  = rmaddr_q;
      xt_d      = xt_q;
      flush_d   = 1'b0;
      do_alloc  = 1'b0;
      do_retire = 1'b0;

      if (flush_q) begin
         // Flush cycle: every input is ignored and the buffer restarts empty.
         for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
            state_d[i] = SLOT_FREE;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Retire looks only at registered slot state, so a writeback never
         // retires in the cycle it arrives.
         if (state_q[head_q] == SLOT_DONE) begin
            if (head_ent.xcpt) begin
               xv_d     = 1'b1;
               flush_d  = 1'b1;
               rmpc_d   = head_ent.pc;
               rmaddr_d = head_ent.xaddr;
               xt_d     = head_ent.xtype;
            end else begin
               do_retire       = 1'b1;
               wen_d           = head_ent.we;
               wval_d          = head_ent.data;
               dest_d          = head_ent.rd;
               wid_d           = head_q;
               state_d[head_q] = SLOT_FREE;
               head_d          = head_q + 1'b1;
            end
         end

         if (alloc_valid) begin
            if (!rob_full && (alloc_id == tail_q)) begin
               do_alloc        = 1'b1;
               state_d[tail_q] = SLOT_PEND;
               tail_d          = tail_q + 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end

         if (alu_cap) begin
            state_d[alu_wb_id] = SLOT_DONE;
            entry_d[alu_wb_id] = alu_ent;
         end
         if (mul_cap) begin
            state_d[mul_wb_id] = SLOT_DONE;
            entry_d[mul_wb_id] = mul_ent;
         end
         if (merge_err) begin
            err_d = 1'b1;
         end

         if (do_alloc && !do_retire) begin
            count_d = count_q + 1'b1;
         end else if (!do_alloc && do_retire) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
            state_q[i] <= SLOT_FREE;
            entry_q[i] <= '0;
         end
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         wen_q    <= 1'b0;
         wval_q   <= '0;
         dest_q   <= '0;
         wid_q    <= '0;
         xv_q     <= 1'b0;
         rmpc_q   <= '0;
         rmaddr_q <= '0;
         xt_q     <= '0;
         flush_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         err_q    <= err_d;
         wen_q    <= wen_d;
         wval_q   <= wval_d;
         dest_q   <= dest_d;
         wid_q    <= wid_d;
         xv_q     <= xv_d;
         rmpc_q   <= rmpc_d;
         rmaddr_q <= rmaddr_d;
         xt_q     <= xt_d;
         flush_q  <= flush_d;
      end
   end

   assign writeEnRF  = wen_q;
   assign writeValRF = wval_q;
   assign destRF     = dest_q;
   assign write_idRF = wid_q;
   assign xcpt_valid = xv_q;
   assign rmPC       = rmpc_q;
   assign rmAddr     = rmaddr_q;
   assign xcpt_type  = xt_q;
   assign flush_rob  = flush_q;
   assign rob_err    = err_q;

endmodule
